// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset main controller: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with memory-ready timeout, sticky trap and retired-instruction counter.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [6:0]       op_q;
  logic [7:0]       wait_q;
  logic             trap_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             waiting;
  logic             timeout;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout = waiting && !mem_ready && (wait_q == WAIT_LAST);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cause_d = CAUSE_NONE;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXECUTE;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXECUTE: state_d = S_ALU_WB;
      S_ALU_WB, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Moore decode; FETCH and BRANCH gate their PC/IR enables with the live handshake inputs.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b10;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
    // The state register resets to FETCH, so the enables must also be masked while reset is held.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (waiting && !mem_ready) begin
        wait_q <= wait_q + 8'd1;
      end
      if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the controller outputs.
module tb_multicycle_control;

  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
                         S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXECUTE = 4'd6, S_ALU_WB = 4'd7,
                         S_BRANCH = 4'd8, S_TRAP = 4'd9;

  localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0]       st;
    logic [12:0]      ctl;
    logic             trap;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a;
  logic [1:0]       alu_src_b, alu_op;
  logic             pc_src, trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;
  logic [12:0]      act_ctl;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_n = 0;
  int   tests = 0;
  int   fails = 0;

  multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .trap(trap), .trap_cause(trap_cause), .instr_count(instr_count), .state(state)
  );

  assign act_ctl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
                    alu_src_a, alu_src_b, alu_op, pc_src};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Control word per state, in act_ctl bit order, taken from the state table.
  function automatic logic [12:0] exp_ctl(input logic [3:0] st, input logic z, input logic rdy);
    logic pcw, irw, io, mr, mw, rw, m2r, asa, pcs;
    logic [1:0] asb, aop;
    {pcw, irw, io, mr, mw, rw, m2r, asa, pcs} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      S_FETCH:     begin pcw = rdy; irw = rdy; mr = 1'b1; asb = 2'b01; end
      S_DECODE:    asb = 2'b10;
      S_MEM_ADDR:  begin asa = 1'b1; asb = 2'b10; end
      S_MEM_READ:  begin mr = 1'b1; io = 1'b1; end
      S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
      S_MEM_WRITE: begin mw = 1'b1; io = 1'b1; end
      S_EXECUTE:   begin asa = 1'b1; aop = 2'b10; end
      S_ALU_WB:    rw = 1'b1;
      S_BRANCH:    begin asa = 1'b1; aop = 2'b01; pcs = 1'b1; pcw = z; end
      default: ;
    endcase
    return {pcw, irw, io, mr, mw, rw, m2r, asa, asb, aop, pcs};
  endfunction

  // Drive this cycle's inputs, record what the DUT must show in this cycle, then advance.
  task automatic cyc(input logic [6:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input int cnt, input logic [1:0] cause);
    exp_t e;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    e.st    = st;
    e.ctl   = exp_ctl(st, z, rdy);
    e.trap  = (st == S_TRAP);
    e.cause = cause;
    e.cnt   = CNT_W'(cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_ctl", 32'(act_ctl), 32'd0);
    check("rst_trap", 32'({trap, trap_cause}), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check($sformatf("c%0d_state", mon_n), 32'(state), 32'(mon_e.st));
      check($sformatf("c%0d_ctl", mon_n), 32'(act_ctl), 32'(mon_e.ctl));
      check($sformatf("c%0d_trap_cause", mon_n), 32'({trap, trap_cause}), 32'({mon_e.trap, mon_e.cause}));
      check($sformatf("c%0d_count", mon_n), 32'(instr_count), 32'(mon_e.cnt));
      mon_n++;
    end
  end

  initial begin
    reset_dut();

    // R-type with zero memory wait: 0,1,6,7,0.
    cyc(OP_R,    0, 1, S_FETCH,   0, 2'b00);
    cyc(OP_R,    0, 1, S_DECODE,  0, 2'b00);
    cyc(OP_R,    0, 1, S_EXECUTE, 0, 2'b00);
    cyc(OP_R,    0, 1, S_ALU_WB,  0, 2'b00);

    // Load with three wait cycles; opcode flips to store after DECODE and must be ignored.
    cyc(OP_LOAD,  0, 1, S_FETCH,    1, 2'b00);
    cyc(OP_LOAD,  0, 1, S_DECODE,   1, 2'b00);
    cyc(OP_STORE, 0, 1, S_MEM_ADDR, 1, 2'b00);
    cyc(OP_STORE, 0, 0, S_MEM_READ, 1, 2'b00);
    cyc(OP_STORE, 0, 0, S_MEM_READ, 1, 2'b00);
    cyc(OP_STORE, 0, 0, S_MEM_READ, 1, 2'b00);
    cyc(OP_STORE, 0, 1, S_MEM_READ, 1, 2'b00);
    cyc(OP_STORE, 0, 1, S_MEM_WB,   1, 2'b00);

    // Store with one wait cycle; opcode flips to load after DECODE.
    cyc(OP_STORE, 0, 1, S_FETCH,     2, 2'b00);
    cyc(OP_STORE, 0, 1, S_DECODE,    2, 2'b00);
    cyc(OP_LOAD,  0, 1, S_MEM_ADDR,  2, 2'b00);
    cyc(OP_LOAD,  0, 0, S_MEM_WRITE, 2, 2'b00);
    cyc(OP_LOAD,  0, 1, S_MEM_WRITE, 2, 2'b00);

    // Branch taken, then not taken.
    cyc(OP_BR, 1, 1, S_FETCH,  3, 2'b00);
    cyc(OP_BR, 1, 1, S_DECODE, 3, 2'b00);
    cyc(OP_BR, 1, 1, S_BRANCH, 3, 2'b00);
    cyc(OP_BR, 0, 1, S_FETCH,  4, 2'b00);
    cyc(OP_BR, 0, 1, S_DECODE, 4, 2'b00);
    cyc(OP_BR, 0, 1, S_BRANCH, 4, 2'b00);

    // Illegal opcode traps with the counter frozen at 5; inputs toggling must not wake it.
    cyc(OP_BAD, 0, 1, S_FETCH,  5, 2'b00);
    cyc(OP_BAD, 0, 1, S_DECODE, 5, 2'b00);
    for (int i = 0; i < 20; i++) cyc(OP_R, i[0], ~i[1], S_TRAP, 5, 2'b01);

    // FETCH timeout: exactly MEM_TIMEOUT cycles without mem_ready.
    reset_dut();
    for (int i = 0; i < MEM_TIMEOUT; i++) cyc(OP_R, 0, 0, S_FETCH, 0, 2'b00);
    for (int i = 0; i < 3; i++) cyc(OP_R, 0, 1, S_TRAP, 0, 2'b10);

    // mem_ready on the last allowed FETCH cycle wins over the timeout.
    reset_dut();
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) cyc(OP_R, 0, 0, S_FETCH, 0, 2'b00);
    cyc(OP_R, 0, 1, S_FETCH,   0, 2'b00);
    cyc(OP_R, 0, 1, S_DECODE,  0, 2'b00);
    cyc(OP_R, 0, 1, S_EXECUTE, 0, 2'b00);
    cyc(OP_R, 0, 1, S_ALU_WB,  0, 2'b00);
    cyc(OP_R, 0, 0, S_FETCH,   1, 2'b00);

    // Reset pulsed in the middle of a stalled MEM_WRITE.
    reset_dut();
    cyc(OP_STORE, 0, 1, S_FETCH,    0, 2'b00);
    cyc(OP_STORE, 0, 1, S_DECODE,   0, 2'b00);
    cyc(OP_STORE, 0, 1, S_MEM_ADDR, 0, 2'b00);
    opcode    = OP_STORE;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("pre_arst_mem_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_ctl", 32'(act_ctl), 32'd0);
    check("arst_state", 32'(state), 32'(S_FETCH));
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_ctl", 32'(act_ctl), 32'd0);
    check("arst_hold_count", 32'(instr_count), 32'd0);
    rst_n = 1'b1;
    cyc(OP_R, 0, 1, S_FETCH,   0, 2'b00);
    cyc(OP_R, 0, 1, S_DECODE,  0, 2'b00);
    cyc(OP_R, 0, 1, S_EXECUTE, 0, 2'b00);
    cyc(OP_R, 0, 1, S_ALU_WB,  0, 2'b00);
    cyc(OP_R, 0, 0, S_FETCH,   1, 2'b00);

    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
